trng_ehr_rd_ctrl: RTL and testbench
===================================

TRNG_EHR_RD_CTRL -- requirements
Module: trng_ehr_rd_ctrl

Interface
REQ-001 SHALL have parameter EHR_WIDTH, default 192, meaning EHR size in bits (integer multiple of 32).
REQ-002 SHALL have parameter NUM_WORDS, default EHR_WIDTH/32 = 6, meaning 32-bit words per EHR.
REQ-003 SHALL have port rng_clk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port rst_trng_logic, input, 1, synchronous clear of all state.
REQ-006 SHALL have port trng_prng_ehr_valid, input, 1, EHR full and readable, from the EHR producer.
REQ-007 SHALL have port ehr_data, input, EHR_WIDTH, producer EHR contents; word k = bits [32k+31:32k].
REQ-008 SHALL have port debug_mode, input, 1, CPU reads are non-consuming when high.
REQ-009 SHALL have port cpu_rd_stb, input, 1, single-cycle CPU read strobe.
REQ-010 SHALL have port cpu_rd_addr, input, 3, word index of the CPU read.
REQ-011 SHALL have port cpu_rd_data, output, 32, registered read data.
REQ-012 SHALL have port cpu_rd_ack, output, 1, pulse one cycle after cpu_rd_stb.
REQ-013 SHALL have port cpu_ehr_rd, output, 1, pulse per consumed CPU word, to the producer bit counter (-32).
REQ-014 SHALL have port cpu_in_mid_rd_of_ehr_not_in_debug_mode, output, 1, CPU drain in progress.
REQ-015 SHALL have port prng_seed_req, input, 1, PRNG requests a seed; level, held until prng_seed_ack.
REQ-016 SHALL have port prng_seed_ack, output, 1, single-cycle pulse; prng_seed_data valid in that cycle.
REQ-017 SHALL have port prng_seed_data, output, EHR_WIDTH, snapshot of the EHR.
REQ-018 SHALL have port prng_trng_ehr_rd, output, 1, pulse; whole EHR consumed by the PRNG.
REQ-019 SHALL have port ehr_rd_err, output, 1, sticky out-of-order read error.

Function
REQ-020 SHALL implement FSM with states IDLE, AVAIL, CPU_RD and PRNG_XFER.
REQ-021 IDLE->AVAIL SHALL occur when trng_prng_ehr_valid=1, loading ehr_data into the shadow register and clearing word_cnt to 0.
REQ-022 AVAIL with cpu_rd_stb, addr==0 and !debug_mode SHALL go to CPU_RD, set word_cnt=1, pulse cpu_ehr_rd and raise the mid-read flag.
REQ-023 AVAIL with prng_seed_req and no qualifying CPU strobe SHALL go to PRNG_XFER.
REQ-024 PRNG_XFER SHALL pulse prng_seed_ack and prng_trng_ehr_rd in the same cycle, then go to IDLE.
REQ-025 On simultaneous qualifying CPU word-0 read and prng_seed_req in AVAIL, the CPU SHALL win; the PRNG SHALL wait until IDLE->AVAIL.
REQ-026 CPU_RD: a strobe with addr==word_cnt SHALL return that shadow word, pulse cpu_ehr_rd and increment word_cnt.
REQ-027 CPU_RD: the read of word NUM_WORDS-1 SHALL clear the mid-read flag and go to IDLE.
REQ-028 CPU_RD: a strobe with addr!=word_cnt SHALL set ehr_rd_err, return 0, produce no cpu_ehr_rd and leave the state unchanged.
REQ-029 prng_seed_req SHALL be ignored while in CPU_RD.
REQ-030 debug_mode=1 reads in AVAIL/CPU_RD SHALL return the shadow word at any addr, without pulses or state change.
REQ-031 Reads in IDLE, or addr>=NUM_WORDS, SHALL return 0 with ack and no error.
REQ-032 cpu_rd_ack SHALL be asserted exactly one cycle after every cpu_rd_stb.
REQ-033 The shadow register SHALL be immutable outside IDLE->AVAIL.
REQ-034 ehr_rd_err SHALL clear only on reset or rst_trng_logic.

Reset
REQ-035 On rst_n=0 the FSM SHALL be IDLE, word_cnt 0, shadow 0, and all outputs 0.
REQ-036 rst_trng_logic=1 SHALL produce the same state in the next cycle, overriding all other events; a drain in progress SHALL be aborted with no pulses.

Structure
REQ-037 FSM state encodings, EHR_WIDTH and NUM_WORDS SHALL reside in the shared cc_params package.
REQ-038 The 32-bit word mux SHALL be sub-module trng_ehr_word_mux; all other logic SHALL be flat.

Verification
REQ-039 Valid high, ehr_data word k=0x1000_000k, CPU reads addr 0..5 -> data 0x10000000..0x10000005, 6 cpu_ehr_rd pulses, mid-rd flag high from read 0 through read 5, then IDLE.
REQ-040 Valid high, prng_seed_req=1 -> ack and prng_trng_ehr_rd pulse together, seed_data==ehr_data, zero cpu_ehr_rd pulses.
REQ-041 In AVAIL, CPU addr 0 and prng_seed_req in the same cycle -> CPU_RD, no seed_ack until 6 words are read and valid is seen again.
REQ-042 In CPU_RD with word_cnt=2, read addr 4 -> data 0, ehr_rd_err=1, word_cnt remains 2; then addr 2 -> correct data.
REQ-043 debug_mode=1, read addr 3 -> word 3 returned, no cpu_ehr_rd, state stays AVAIL.
REQ-044 rst_trng_logic after 3 CPU words -> next cycle IDLE, flag 0, err 0, no pulses.

Source files
------------

// File: rtl/cc_params.sv
// Shared sizing and FSM encoding for the TRNG entropy-holding-register read path.
package cc_params;

  localparam int unsigned CC_EHR_WIDTH = 192;
  localparam int unsigned CC_NUM_WORDS = CC_EHR_WIDTH / 32;
  localparam int unsigned CC_ADDR_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_AVAIL     = 2'd1,
    ST_CPU_RD    = 2'd2,
    ST_PRNG_XFER = 2'd3
  } ehr_rd_state_e;

endpackage

// File: rtl/trng_ehr_word_mux.sv
// Selects one 32-bit word of the EHR shadow; out-of-range indices read as zero.
module trng_ehr_word_mux
  import cc_params::*;
#(
  parameter int unsigned EHR_WIDTH = CC_EHR_WIDTH,
  parameter int unsigned NUM_WORDS = CC_NUM_WORDS
) (
  input  logic [EHR_WIDTH-1:0] i_ehr,
  input  logic [CC_ADDR_W-1:0] i_addr,
  output logic [31:0]          o_word
);

  always_comb begin
    o_word = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (i_addr == CC_ADDR_W'(k)) o_word = i_ehr[32*k +: 32];
    end
  end

endmodule

// File: rtl/trng_ehr_rd_ctrl.sv
// Arbitrates a captured EHR between an in-order CPU word drain and a whole-EHR PRNG seed transfer.
module trng_ehr_rd_ctrl
  import cc_params::*;
#(
  parameter int unsigned EHR_WIDTH = CC_EHR_WIDTH,
  parameter int unsigned NUM_WORDS = EHR_WIDTH / 32
) (
  input  logic                 rng_clk,
  input  logic                 rst_n,
  input  logic                 rst_trng_logic,
  input  logic                 trng_prng_ehr_valid,
  input  logic [EHR_WIDTH-1:0] ehr_data,
  input  logic                 debug_mode,
  input  logic                 cpu_rd_stb,
  input  logic [CC_ADDR_W-1:0] cpu_rd_addr,
  output logic [31:0]          cpu_rd_data,
  output logic                 cpu_rd_ack,
  output logic                 cpu_ehr_rd,
  output logic                 cpu_in_mid_rd_of_ehr_not_in_debug_mode,
  input  logic                 prng_seed_req,
  output logic                 prng_seed_ack,
  output logic [EHR_WIDTH-1:0] prng_seed_data,
  output logic                 prng_trng_ehr_rd,
  output logic                 ehr_rd_err
);

  localparam logic [CC_ADDR_W:0]   NUM_LIM  = (CC_ADDR_W + 1)'(NUM_WORDS);
  localparam logic [CC_ADDR_W-1:0] LAST_IDX = CC_ADDR_W'(NUM_WORDS - 1);

  ehr_rd_state_e          r_state, w_state_nxt;
  logic [CC_ADDR_W-1:0]   r_word_cnt, w_cnt_nxt;
  logic [EHR_WIDTH-1:0]   r_shadow;
  logic [31:0]            r_rd_data, w_data_nxt;
  logic                   r_ack;
  logic                   r_cpu_ehr_rd, w_cpu_ehr_rd_nxt;
  logic                   r_mid_rd, w_mid_nxt;
  logic                   r_seed_ack, w_seed_ack_nxt;
  logic                   r_prng_rd, w_prng_rd_nxt;
  logic                   r_err, w_err_nxt;
  logic                   w_shadow_ld;
  logic                   w_in_range;
  logic [31:0]            w_word;

  trng_ehr_word_mux #(
    .EHR_WIDTH (EHR_WIDTH),
    .NUM_WORDS (NUM_WORDS)
  ) u_word_mux (
    .i_ehr  (r_shadow),
    .i_addr (cpu_rd_addr),
    .o_word (w_word)
  );

  assign w_in_range = ({1'b0, cpu_rd_addr} < NUM_LIM);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_word_cnt;
    w_shadow_ld      = 1'b0;
    w_data_nxt       = r_rd_data;
    w_cpu_ehr_rd_nxt = 1'b0;
    w_mid_nxt        = r_mid_rd;
    w_seed_ack_nxt   = 1'b0;
    w_prng_rd_nxt    = 1'b0;
    w_err_nxt        = r_err;
    // Every strobe returns zero unless a branch below supplies a word.
    if (cpu_rd_stb) w_data_nxt = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (trng_prng_ehr_valid) begin
          w_state_nxt = ST_AVAIL;
          w_shadow_ld = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ST_AVAIL: begin
        if (cpu_rd_stb && debug_mode) begin
          w_data_nxt = w_word;
        end else if (cpu_rd_stb && w_in_range) begin
          if (cpu_rd_addr == '0) begin
            w_data_nxt       = w_word;
            w_cpu_ehr_rd_nxt = 1'b1;
            w_cnt_nxt        = CC_ADDR_W'(1);
            w_mid_nxt        = (LAST_IDX != '0);
            w_state_nxt      = (LAST_IDX != '0) ? ST_CPU_RD : ST_IDLE;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        // A word-0 CPU drain start takes priority; the PRNG retries after the next capture.
        if (w_state_nxt == ST_AVAIL && prng_seed_req) w_state_nxt = ST_PRNG_XFER;
      end
      ST_CPU_RD: begin
        if (cpu_rd_stb && debug_mode) begin
          w_data_nxt = w_word;
        end else if (cpu_rd_stb && w_in_range) begin
          if (cpu_rd_addr == r_word_cnt) begin
            w_data_nxt       = w_word;
            w_cpu_ehr_rd_nxt = 1'b1;
            w_cnt_nxt        = r_word_cnt + CC_ADDR_W'(1);
            if (r_word_cnt == LAST_IDX) begin
              w_mid_nxt   = 1'b0;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_PRNG_XFER: begin
        w_seed_ack_nxt = 1'b1;
        w_prng_rd_nxt  = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n)              r_state <= ST_IDLE;
    else if (rst_trng_logic) r_state <= ST_IDLE;
    else                     r_state <= w_state_nxt;
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt   <= '0;
      r_shadow     <= '0;
      r_rd_data    <= '0;
      r_ack        <= 1'b0;
      r_cpu_ehr_rd <= 1'b0;
      r_mid_rd     <= 1'b0;
      r_seed_ack   <= 1'b0;
      r_prng_rd    <= 1'b0;
      r_err        <= 1'b0;
    end else if (rst_trng_logic) begin
      r_word_cnt   <= '0;
      r_shadow     <= '0;
      r_rd_data    <= '0;
      r_ack        <= 1'b0;
      r_cpu_ehr_rd <= 1'b0;
      r_mid_rd     <= 1'b0;
      r_seed_ack   <= 1'b0;
      r_prng_rd    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_word_cnt   <= w_cnt_nxt;
      if (w_shadow_ld) r_shadow <= ehr_data;
      r_rd_data    <= w_data_nxt;
      r_ack        <= cpu_rd_stb;
      r_cpu_ehr_rd <= w_cpu_ehr_rd_nxt;
      r_mid_rd     <= w_mid_nxt;
      r_seed_ack   <= w_seed_ack_nxt;
      r_prng_rd    <= w_prng_rd_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign cpu_rd_data                            = r_rd_data;
  assign cpu_rd_ack                             = r_ack;
  assign cpu_ehr_rd                             = r_cpu_ehr_rd;
  assign cpu_in_mid_rd_of_ehr_not_in_debug_mode = r_mid_rd;
  assign prng_seed_ack                          = r_seed_ack;
  assign prng_seed_data                         = r_shadow;
  assign prng_trng_ehr_rd                       = r_prng_rd;
  assign ehr_rd_err                             = r_err;

endmodule

// File: tb/tb_trng_ehr_rd_ctrl.sv
// Directed bench for the EHR read controller: CPU drain, PRNG transfer, contention, errors, debug and sync clear.
module tb_trng_ehr_rd_ctrl;

  localparam int W = 192;
  localparam int N = 6;

  logic          rng_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rst_trng_logic = 1'b0;
  logic          trng_prng_ehr_valid = 1'b0;
  logic [W-1:0]  ehr_data = '0;
  logic          debug_mode = 1'b0;
  logic          cpu_rd_stb = 1'b0;
  logic [2:0]    cpu_rd_addr = '0;
  logic [31:0]   cpu_rd_data;
  logic          cpu_rd_ack;
  logic          cpu_ehr_rd;
  logic          mid_rd;
  logic          prng_seed_req = 1'b0;
  logic          prng_seed_ack;
  logic [W-1:0]  prng_seed_data;
  logic          prng_trng_ehr_rd;
  logic          ehr_rd_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_cpu_rd = 0;
  int cnt_seed_ack = 0;
  int cnt_prng_rd = 0;
  logic [31:0] pat [N];

  trng_ehr_rd_ctrl #(.EHR_WIDTH(W), .NUM_WORDS(N)) dut (
    .rng_clk                                (rng_clk),
    .rst_n                                  (rst_n),
    .rst_trng_logic                         (rst_trng_logic),
    .trng_prng_ehr_valid                    (trng_prng_ehr_valid),
    .ehr_data                               (ehr_data),
    .debug_mode                             (debug_mode),
    .cpu_rd_stb                             (cpu_rd_stb),
    .cpu_rd_addr                            (cpu_rd_addr),
    .cpu_rd_data                            (cpu_rd_data),
    .cpu_rd_ack                             (cpu_rd_ack),
    .cpu_ehr_rd                             (cpu_ehr_rd),
    .cpu_in_mid_rd_of_ehr_not_in_debug_mode (mid_rd),
    .prng_seed_req                          (prng_seed_req),
    .prng_seed_ack                          (prng_seed_ack),
    .prng_seed_data                         (prng_seed_data),
    .prng_trng_ehr_rd                       (prng_trng_ehr_rd),
    .ehr_rd_err                             (ehr_rd_err)
  );

  always #5 rng_clk = ~rng_clk;

  always @(negedge rng_clk) begin
    if (rst_n) begin
      if (cpu_ehr_rd)       cnt_cpu_rd++;
      if (prng_seed_ack)    cnt_seed_ack++;
      if (prng_trng_ehr_rd) cnt_prng_rd++;
    end
  end

  task automatic tick();
    @(posedge rng_clk);
    #1;
  endtask

  task automatic set_pattern(input logic [31:0] base, input logic [31:0] step);
    for (int k = 0; k < N; k++) begin
      pat[k] = base + k * step;
      ehr_data[32*k +: 32] = pat[k];
    end
  endtask

  task automatic load_ehr();
    trng_prng_ehr_valid = 1'b1;
    tick();
    trng_prng_ehr_valid = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a);
    cpu_rd_stb  = 1'b1;
    cpu_rd_addr = a;
    tick();
    cpu_rd_stb  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++; if (cpu_rd_data !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h exp 0", cpu_rd_data); end
    n_cmp++; if ({cpu_rd_ack, cpu_ehr_rd, mid_rd, prng_seed_ack, prng_trng_ehr_rd, ehr_rd_err} !== 6'b0) begin n_bad++; $display("FAIL rst_flags got %b exp 000000", {cpu_rd_ack, cpu_ehr_rd, mid_rd, prng_seed_ack, prng_trng_ehr_rd, ehr_rd_err}); end
    n_cmp++; if (prng_seed_data !== '0) begin n_bad++; $display("FAIL rst_seed got %h exp 0", prng_seed_data); end
    rst_n = 1'b1;
    tick();
    // read while IDLE: zero data, ack, no error
    cpu_read(3'd0);
    n_cmp++; if (cpu_rd_ack !== 1'b1) begin n_bad++; $display("FAIL idle_ack got %b exp 1", cpu_rd_ack); end
    n_cmp++; if (cpu_rd_data !== 32'h0) begin n_bad++; $display("FAIL idle_data got %h exp 0", cpu_rd_data); end
    n_cmp++; if ({cpu_ehr_rd, ehr_rd_err} !== 2'b00) begin n_bad++; $display("FAIL idle_flags got %b exp 00", {cpu_ehr_rd, ehr_rd_err}); end
    tick();
    n_cmp++; if (cpu_rd_ack !== 1'b0) begin n_bad++; $display("FAIL ack_single got %b exp 0", cpu_rd_ack); end
  endtask

  task automatic test_cpu_drain();
    int c0;
    c0 = cnt_cpu_rd;
    set_pattern(32'h1000_0000, 32'h1);
    load_ehr();
    for (int k = 0; k < N; k++) begin
      cpu_read(3'(k));
      n_cmp++; if (cpu_rd_data !== 32'h1000_0000 + k) begin n_bad++; $display("FAIL drain_data%0d got %h exp %h", k, cpu_rd_data, 32'h1000_0000 + k); end
      n_cmp++; if ({cpu_rd_ack, cpu_ehr_rd} !== 2'b11) begin n_bad++; $display("FAIL drain_pulse%0d got %b exp 11", k, {cpu_rd_ack, cpu_ehr_rd}); end
      n_cmp++; if (mid_rd !== (k < N - 1)) begin n_bad++; $display("FAIL drain_mid%0d got %b exp %b", k, mid_rd, (k < N - 1)); end
      if (k == 2) begin
        cpu_read(3'd6);
        n_cmp++; if ({cpu_rd_data, cpu_rd_ack, cpu_ehr_rd, ehr_rd_err} !== {32'h0, 3'b100}) begin n_bad++; $display("FAIL range_read got %h/%b%b%b exp 0/100", cpu_rd_data, cpu_rd_ack, cpu_ehr_rd, ehr_rd_err); end
      end
    end
    tick();
    n_cmp++; if (cnt_cpu_rd - c0 !== 6) begin n_bad++; $display("FAIL drain_count got %0d exp 6", cnt_cpu_rd - c0); end
    n_cmp++; if ({cpu_rd_ack, cpu_ehr_rd, ehr_rd_err} !== 3'b000) begin n_bad++; $display("FAIL drain_end got %b exp 000", {cpu_rd_ack, cpu_ehr_rd, ehr_rd_err}); end
  endtask

  task automatic test_prng();
    logic [W-1:0] exp_seed;
    int c0;
    c0 = cnt_cpu_rd;
    set_pattern(32'hA5A5_0000, 32'h0000_0111);
    exp_seed = ehr_data;
    load_ehr();
    prng_seed_req = 1'b1;
    set_pattern(32'hDEAD_0000, 32'h3);
    tick();
    n_cmp++; if ({prng_seed_ack, prng_trng_ehr_rd} !== 2'b00) begin n_bad++; $display("FAIL prng_early got %b exp 00", {prng_seed_ack, prng_trng_ehr_rd}); end
    tick();
    n_cmp++; if ({prng_seed_ack, prng_trng_ehr_rd} !== 2'b11) begin n_bad++; $display("FAIL prng_ack got %b exp 11", {prng_seed_ack, prng_trng_ehr_rd}); end
    n_cmp++; if (prng_seed_data !== exp_seed) begin n_bad++; $display("FAIL prng_seed got %h exp %h", prng_seed_data, exp_seed); end
    prng_seed_req = 1'b0;
    tick();
    n_cmp++; if ({prng_seed_ack, prng_trng_ehr_rd} !== 2'b00) begin n_bad++; $display("FAIL prng_single got %b exp 00", {prng_seed_ack, prng_trng_ehr_rd}); end
    n_cmp++; if (cnt_cpu_rd - c0 !== 0) begin n_bad++; $display("FAIL prng_cpu_pulses got %0d exp 0", cnt_cpu_rd - c0); end
  endtask

  task automatic test_contention();
    int s0;
    s0 = cnt_seed_ack;
    set_pattern(32'h2000_0000, 32'h10);
    load_ehr();
    prng_seed_req = 1'b1;
    for (int k = 0; k < N; k++) begin
      cpu_read(3'(k));
      n_cmp++; if ({cpu_rd_data, cpu_ehr_rd} !== {pat[k], 1'b1}) begin n_bad++; $display("FAIL cont_read%0d got %h/%b exp %h/1", k, cpu_rd_data, cpu_ehr_rd, pat[k]); end
    end
    repeat (3) tick();
    n_cmp++; if (cnt_seed_ack - s0 !== 0) begin n_bad++; $display("FAIL cont_no_ack got %0d exp 0", cnt_seed_ack - s0); end
    load_ehr();
    tick();
    n_cmp++; if (prng_seed_ack !== 1'b0) begin n_bad++; $display("FAIL cont_ack_early got %b exp 0", prng_seed_ack); end
    tick();
    n_cmp++; if ({prng_seed_ack, prng_trng_ehr_rd} !== 2'b11) begin n_bad++; $display("FAIL cont_ack got %b exp 11", {prng_seed_ack, prng_trng_ehr_rd}); end
    prng_seed_req = 1'b0;
    tick();
    n_cmp++; if (cnt_seed_ack - s0 !== 1) begin n_bad++; $display("FAIL cont_ack_count got %0d exp 1", cnt_seed_ack - s0); end
  endtask

  task automatic test_debug_and_clear();
    int c0;
    c0 = cnt_cpu_rd;
    set_pattern(32'h3000_0000, 32'h101);
    load_ehr();
    debug_mode = 1'b1;
    cpu_read(3'd3);
    debug_mode = 1'b0;
    n_cmp++; if (cpu_rd_data !== 32'h3000_0303) begin n_bad++; $display("FAIL dbg_data got %h exp 30000303", cpu_rd_data); end
    n_cmp++; if ({cpu_rd_ack, cpu_ehr_rd, mid_rd, ehr_rd_err} !== 4'b1000) begin n_bad++; $display("FAIL dbg_flags got %b exp 1000", {cpu_rd_ack, cpu_ehr_rd, mid_rd, ehr_rd_err}); end
    for (int k = 0; k < 3; k++) begin
      cpu_read(3'(k));
      n_cmp++; if ({cpu_rd_data, cpu_ehr_rd, mid_rd} !== {pat[k], 2'b11}) begin n_bad++; $display("FAIL dbg_after%0d got %h/%b%b exp %h/11", k, cpu_rd_data, cpu_ehr_rd, mid_rd, pat[k]); end
    end
    rst_trng_logic = 1'b1;
    cpu_rd_stb = 1'b1;
    cpu_rd_addr = 3'd3;
    tick();
    rst_trng_logic = 1'b0;
    cpu_rd_stb = 1'b0;
    n_cmp++; if ({cpu_rd_ack, cpu_ehr_rd, mid_rd, ehr_rd_err} !== 4'b0000) begin n_bad++; $display("FAIL clr_flags got %b exp 0000", {cpu_rd_ack, cpu_ehr_rd, mid_rd, ehr_rd_err}); end
    n_cmp++; if ({cpu_rd_data, prng_seed_data} !== '0) begin n_bad++; $display("FAIL clr_data got %h/%h exp 0", cpu_rd_data, prng_seed_data); end
    cpu_read(3'd3);
    n_cmp++; if ({cpu_rd_data, cpu_rd_ack, cpu_ehr_rd, ehr_rd_err} !== {32'h0, 3'b100}) begin n_bad++; $display("FAIL clr_idle got %h/%b%b%b exp 0/100", cpu_rd_data, cpu_rd_ack, cpu_ehr_rd, ehr_rd_err); end
    tick();
    n_cmp++; if (cnt_cpu_rd - c0 !== 3) begin n_bad++; $display("FAIL clr_count got %0d exp 3", cnt_cpu_rd - c0); end
  endtask

  task automatic test_out_of_order();
    set_pattern(32'h4000_0000, 32'h7);
    load_ehr();
    cpu_read(3'd0);
    cpu_read(3'd1);
    cpu_read(3'd4);
    n_cmp++; if (cpu_rd_data !== 32'h0) begin n_bad++; $display("FAIL ooo_data got %h exp 0", cpu_rd_data); end
    n_cmp++; if ({cpu_rd_ack, cpu_ehr_rd, mid_rd, ehr_rd_err} !== 4'b1011) begin n_bad++; $display("FAIL ooo_flags got %b exp 1011", {cpu_rd_ack, cpu_ehr_rd, mid_rd, ehr_rd_err}); end
    cpu_read(3'd2);
    n_cmp++; if ({cpu_rd_data, cpu_ehr_rd, ehr_rd_err} !== {32'h4000_000E, 2'b11}) begin n_bad++; $display("FAIL ooo_resume got %h/%b%b exp 4000000e/11", cpu_rd_data, cpu_ehr_rd, ehr_rd_err); end
    for (int k = 3; k < N; k++) cpu_read(3'(k));
    n_cmp++; if ({cpu_rd_data, mid_rd, ehr_rd_err} !== {pat[N-1], 2'b01}) begin n_bad++; $display("FAIL ooo_end got %h/%b%b exp %h/01", cpu_rd_data, mid_rd, ehr_rd_err, pat[N-1]); end
    repeat (2) tick();
    n_cmp++; if (ehr_rd_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b exp 1", ehr_rd_err); end
    rst_trng_logic = 1'b1;
    tick();
    rst_trng_logic = 1'b0;
    n_cmp++; if (ehr_rd_err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b exp 0", ehr_rd_err); end
  endtask

  initial begin
    test_reset();
    test_cpu_drain();
    test_prng();
    test_contention();
    test_debug_and_clear();
    test_out_of_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
